// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared definitions for the instruction fetch slice. Contents:
//           - fetch FSM state encoding
//           - EBREAK encoding
//           - default NOP substitution word
//           - fetch-address legality helper
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] EBREAK_INSTR      = 32'h0010_0073;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // A fetch is illegal when it falls outside the memory or is not word aligned.
  function automatic logic bad_fetch(input logic [31:0] pc, input logic [31:0] limit_bytes);
    return (pc >= limit_bytes) || (pc[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Purpose : IF/ID pipeline register with valid/ready hold logic.
// Ports   : clk_i    - rising-edge clock
//           rst_ni   - asynchronous active-low reset
//           flush_i  - drop the held word (takes priority over load)
//           load_i   - capture instr_i / pc_i and mark valid
//           ready_i  - consumer accepts the held word (drains when not loading)
//           instr_i  - instruction word to capture
//           pc_i     - address of instr_i
//           valid_o  - register holds a valid word
//           instr_o  - held instruction
//           pc_o     - address of held instruction
// Rev     : 1.0  initial release
// ============================================================================
module if_id_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        ready_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (ready_i) begin
      // Word consumed with nothing new behind it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Purpose : Program counter and BOOT/RUN/HALT fetch FSM feeding an IF/ID
//           register. Illegal fetches substitute NOP_INSTR and set a sticky
//           fault; a captured EBREAK halts; redirects flush and resume.
// Ports   : clk            - rising-edge clock
//           rst_n          - asynchronous active-low reset
//           addr           - fetch byte address (equals pc)
//           instruction    - memory word for addr (combinational)
//           redirect_valid - load redirect_pc, flush IF/ID, leave HALT
//           redirect_pc    - redirect target
//           id_ready       - decode accepts the IF/ID word
//           if_id_valid    - IF/ID word valid
//           if_id_instr    - fetched instruction
//           if_id_pc       - address of if_id_instr
//           fetch_fault    - sticky illegal-fetch flag
//           halted         - FSM is in HALT
// Rev     : 1.0  initial release
// ============================================================================
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 16,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] addr,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        fetch_fault,
  output logic        halted
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) * 32'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         halted_q;

  logic         ifid_valid;
  logic         ifid_load;
  logic         ifid_flush;
  logic         advance;
  logic         fetch_bad;
  logic [31:0]  fetch_word;

  assign advance    = !ifid_valid || id_ready;
  assign fetch_bad  = bad_fetch(pc_q, IMEM_BYTES);
  assign fetch_word = fetch_bad ? NOP_INSTR : instruction;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Redirects are ignored while booting.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // Redirect wins over stall and over an EBREAK fetched this cycle.
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (advance) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
          if (fetch_bad) begin
            fault_d = 1'b1;
          end
          if (fetch_word == EBREAK_INSTR) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      // Registered alongside the state so it always matches state_q.
      halted_q <= (state_d == ST_HALT);
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .ready_i (id_ready),
    .instr_i (fetch_word),
    .pc_i    (pc_q),
    .valid_o (ifid_valid),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc)
  );

  assign addr        = pc_q;
  assign if_id_valid = ifid_valid;
  assign fetch_fault = fault_q;
  assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch
// Purpose : Self-checking bench for instruction_fetch: directed scenarios
//           followed by randomized redirect/stall/reset traffic, all checked
//           against a cycle-level behavioural model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          WORDS  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        fetch_fault;
  logic        halted;

  logic [31:0] mem [WORDS];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_fault, m_boot, m_halt;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr           (addr),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .fetch_fault    (fetch_fault),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Memory returns the containing word even for misaligned addresses, so the
  // DUT must be the one substituting the NOP.
  always_comb begin
    if (addr < 32'(WORDS * 4)) instruction = mem[addr[5:2]];
    else                       instruction = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_valid = 0; m_fault = 0; m_boot = 1; m_halt = 0;
  endtask

  // One clock edge of the fetch rules applied to the current inputs.
  task automatic model_edge();
    logic        bad;
    logic [31:0] w;
    if (m_boot) begin
      m_boot = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      if (id_ready) m_valid = 0;
    end else if (!m_valid || id_ready) begin
      bad = (m_pc >= 32'(WORDS * 4)) || (m_pc % 4 != 0);
      w   = bad ? NOP : mem[m_pc / 4];
      m_instr = w; m_ipc = m_pc; m_valid = 1;
      m_pc = m_pc + 32'd4;
      if (bad) m_fault = 1;
      if (w == EBREAK) m_halt = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},   addr,                 m_pc);
    check({tag, ".valid"},  {31'b0, if_id_valid}, {31'b0, m_valid});
    check({tag, ".fault"},  {31'b0, fetch_fault}, {31'b0, m_fault});
    check({tag, ".halted"}, {31'b0, halted},      {31'b0, m_halt});
    if (m_valid) begin
      check({tag, ".instr"}, if_id_instr, m_instr);
      check({tag, ".ipc"},   if_id_pc,    m_ipc);
    end
  endtask

  task automatic step(input string tag);
    if (!rst_n) model_reset();
    else        model_edge();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".addr"},   addr,                 32'h0);
    check({tag, ".valid"},  {31'b0, if_id_valid}, 32'h0);
    check({tag, ".instr"},  if_id_instr,          32'h0);
    check({tag, ".ipc"},    if_id_pc,             32'h0);
    check({tag, ".fault"},  {31'b0, fetch_fault}, 32'h0);
    check({tag, ".halted"}, {31'b0, halted},      32'h0);
  endtask

  // Called at posedge+1: assert reset mid-cycle, check it bites immediately.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_values(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333; mem[3] = EBREAK;
    for (int i = 4; i < WORDS; i++) begin
      v = $urandom;
      if (v == EBREAK) v = v ^ 32'h1;
      mem[i] = v;
    end

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    model_reset();
    #12 check_reset_values("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot cycle, then sequential fetch
    step("boot");
    check("boot.valid0", {31'b0, if_id_valid}, 32'h0);
    step("f0");
    check("f0.instr", if_id_instr, 32'h1111_1111);
    check("f0.pc",    if_id_pc,    32'h0);
    step("f1");
    check("f1.instr", if_id_instr, 32'h2222_2222);
    check("f1.pc",    if_id_pc,    32'h4);

    // Stall three cycles
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.instr", if_id_instr, 32'h2222_2222);
      check("stall.addr",  addr,        32'h8);
    end
    id_ready = 1'b1;
    step("unstall");
    check("unstall.instr", if_id_instr, 32'h3333_3333);
    check("unstall.pc",    if_id_pc,    32'h8);

    // Redirect to 0: one bubble then 11111111
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step("redir0");
    check("redir0.bubble", {31'b0, if_id_valid}, 32'h0);
    redirect_valid = 1'b0;
    step("redir0.f");
    check("redir0.instr", if_id_instr, 32'h1111_1111);

    // Free-run into EBREAK at 0xC
    step("run4");
    step("run8");
    step("ebreak");
    check("ebreak.instr",  if_id_instr,      EBREAK);
    check("ebreak.halted", {31'b0, halted},  32'h1);
    step("halt.drain");
    check("halt.addr",  addr,                 32'h10);
    check("halt.valid", {31'b0, if_id_valid}, 32'h0);
    step("halt.hold");
    check("halt.addr2", addr, 32'h10);

    // Redirect out of HALT
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    step("unhalt");
    check("unhalt.halted", {31'b0, halted}, 32'h0);
    redirect_valid = 1'b0;
    step("unhalt.f");
    check("unhalt.instr", if_id_instr, 32'h2222_2222);

    // Out-of-range fetch
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step("oor.redir");
    redirect_valid = 1'b0;
    step("oor.f");
    check("oor.instr", if_id_instr,          NOP);
    check("oor.fault", {31'b0, fetch_fault}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step("back.redir");
    redirect_valid = 1'b0;
    step("back.f");
    check("back.fault", {31'b0, fetch_fault}, 32'h1);
    check("back.instr", if_id_instr,          32'h1111_1111);

    // Misaligned fetch
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step("mis.redir");
    redirect_valid = 1'b0;
    step("mis.f");
    check("mis.instr", if_id_instr, NOP);

    // Reset in the middle of a stall
    id_ready = 1'b0;
    step("pre.stall");
    step("pre.stall");
    pulse_reset("midrst");
    id_ready = 1'b1;
    step("rst.boot");
    step("rst.f0");
    check("rst.instr", if_id_instr, 32'h1111_1111);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 32'($urandom_range(0, 23)) * 32'd4;
      if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd.rst");
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_WORDS, default 16, meaning the instruction memory depth in 32-bit words.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the word substituted on a fetch fault.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The port list SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- addr  output  32  byte address to instruction memory; always equals pc.
- instruction  input  32  word returned combinationally by memory for addr.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  redirect target.
- id_ready  input  1  decode stage accepts the IF/ID word this cycle.
- if_id_valid  output  1  IF/ID register holds a valid word.
- if_id_instr  output  32  fetched instruction.
- if_id_pc  output  32  address of if_id_instr.
- fetch_fault  output  1  sticky; an out-of-range or misaligned fetch occurred.
- halted  output  1  FSM is in HALT.

Function
REQ-006 The FSM SHALL have states BOOT, RUN and HALT; reset enters BOOT.
REQ-007 BOOT SHALL last exactly one cycle with if_id_valid=0 and then go to RUN; the first valid word therefore appears in the second cycle after reset release.
REQ-008 In RUN, when the IF/ID register is empty or id_ready=1 (advance), IF/ID SHALL capture {instruction, pc}, set if_id_valid=1, and pc SHALL become pc+4.
REQ-009 In RUN with if_id_valid=1 and id_ready=0 (stall), pc, if_id_instr, if_id_pc and if_id_valid SHALL hold.
REQ-010 A fetch is out of range when pc >= IMEM_WORDS*4 and misaligned when pc[1:0]!=0; such a fetch SHALL capture NOP_INSTR instead of instruction and SHALL set fetch_fault.
REQ-011 fetch_fault SHALL stay set until reset.
REQ-012 A captured instruction of 32'h0010_0073 (EBREAK) SHALL move the FSM to HALT.
REQ-013 In HALT, pc SHALL hold, no new word SHALL be captured, and the pending IF/ID word SHALL drain normally on id_ready.
REQ-014 redirect_valid=1 in any state except BOOT SHALL:
- load pc with redirect_pc;
- clear if_id_valid on the next edge, giving a one-bubble flush;
- move HALT to RUN.
REQ-015 Redirect SHALL take priority over stall and over an EBREAK captured in the same cycle.
REQ-016 redirect_pc SHALL be loaded unmodified; a misaligned target faults per REQ-010 when fetched.
REQ-017 pc+4 SHALL wrap modulo 2^32 with no flag beyond REQ-010.
REQ-018 halted SHALL be a registered decode of state HALT.

Reset
REQ-019 Asserting rst_n=0 at any time, including mid-stall or in HALT, SHALL immediately set:
- pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0;
- fetch_fault=0, halted=0, state=BOOT.
REQ-020 Release SHALL take effect on the first rising clk edge with rst_n=1.

Structure
REQ-021 The state encoding, the EBREAK encoding and the NOP_INSTR default SHALL live in shared package cpu_pkg.
REQ-022 The IF/ID register with its valid/ready hold logic SHALL be one sub-module, if_id_reg; the PC and FSM SHALL stay in instruction_fetch.

Verification
REQ-023 The bench SHALL cover these directed scenarios, using a memory model with words 0..3 = 11111111, 22222222, 33333333, 00100073:
- Reset, id_ready=1 -> cycle 2: if_id_instr=11111111 with if_id_pc=0; then 22222222 @4, 33333333 @8.
- id_ready=0 for 3 cycles with 22222222 held -> if_id_instr and pc unchanged; the next word after release is 33333333.
- redirect_valid with redirect_pc=0 while 33333333 is in IF/ID -> one cycle if_id_valid=0, then 11111111 @0.
- Free-run to address C -> 00100073 captured, halted=1 next cycle, addr frozen at 10; a later redirect to 4 -> halted=0 and 22222222 fetched.
- Redirect to 40 -> if_id_instr=00000013, fetch_fault=1 and still 1 after a redirect back to 0.
- rst_n pulsed low mid-stall -> all outputs at reset values within the same cycle; the sequence restarts at 11111111.
